// File: rtl/lfsr_galois_gen_if.sv
// Bundle of the LFSR control inputs and registered outputs.
// The master side drives en/load/din; the slave side (the generator) drives the outputs.
interface lfsr_galois_gen_if #(
    parameter int WIDTH = 26,
    parameter int STEPS = 1
);
    logic             en;
    logic             load;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] q;
    logic [STEPS-1:0] bit_out;
    logic             wrap;
    logic [WIDTH-1:0] period;
    logic             period_sat;

    modport master (
        output en, load, din,
        input  q, bit_out, wrap, period, period_sat
    );

    modport slave (
        input  en, load, din,
        output q, bit_out, wrap, period, period_sat
    );
endinterface

// File: rtl/lfsr_galois_gen.sv
// Parametrised Galois-form LFSR with advance enable, seed load, zero-lockout
// recovery and wrap detection that measures the period in enabled cycles.
// Each enabled clock advances STEPS single shifts, unrolled combinationally.
module lfsr_galois_gen #(
    parameter int               WIDTH = 26,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(26'h0000182),
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(1),
    parameter int               STEPS = 1
) (
    input  logic            clk,
    input  logic            rst,
    lfsr_galois_gen_if.slave bus
);

    // A zero seed would lock the register, so it is replaced by 1.
    localparam logic [WIDTH-1:0] SEED_EFF = (SEED == '0) ? WIDTH'(1) : SEED;
    // Stage 0 always takes the MSB, so bit 0 of the mask is forced on.
    localparam logic [WIDTH-1:0] FB_MASK  = {TAPS[WIDTH-1:1], 1'b1};
    localparam logic [WIDTH-1:0] ALL_ONES = '1;

    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] active_seed_r;
    logic [WIDTH-1:0] cnt_r;
    logic [WIDTH-1:0] period_r;
    logic             period_sat_r;
    logic             wrap_r;
    logic [STEPS-1:0] bits_r;

    logic [WIDTH-1:0] adv_state;
    logic [STEPS-1:0] adv_bits;
    logic [WIDTH-1:0] cnt_inc;
    logic [WIDTH-1:0] load_val;

    // One Galois shift: rotate left and fold the outgoing MSB into the tapped stages.
    function automatic logic [WIDTH-1:0] shift_once(input logic [WIDTH-1:0] s);
        logic msb;
        msb = s[WIDTH-1];
        return {s[WIDTH-2:0], 1'b0} ^ (FB_MASK & {WIDTH{msb}});
    endfunction

    // Unroll STEPS shifts and collect the MSB seen before each one.
    always_comb begin
        adv_state = q_r;
        adv_bits  = '0;
        for (int j = 0; j < STEPS; j++) begin
            adv_bits[j] = adv_state[WIDTH-1];
            adv_state   = shift_once(adv_state);
        end
    end

    // Saturating period counter increment and the sanitised load value.
    always_comb begin
        cnt_inc  = (cnt_r == ALL_ONES) ? cnt_r : cnt_r + WIDTH'(1);
        load_val = (|bus.din) ? bus.din : WIDTH'(1);
    end

    // State, wrap detection and period measurement; rst > load > lockout > en > hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_r           <= SEED_EFF;
            active_seed_r <= SEED_EFF;
            bits_r        <= '0;
            wrap_r        <= 1'b0;
            period_r      <= '0;
            period_sat_r  <= 1'b0;
            cnt_r         <= '0;
        end else if (bus.load) begin
            q_r           <= load_val;
            active_seed_r <= load_val;
            cnt_r         <= '0;
            wrap_r        <= 1'b0;
            bits_r        <= '0;
        end else if (q_r == '0) begin
            q_r    <= WIDTH'(1);
            cnt_r  <= '0;
            wrap_r <= 1'b0;
        end else if (bus.en) begin
            q_r    <= adv_state;
            bits_r <= adv_bits;
            if (adv_state == active_seed_r) begin
                wrap_r       <= 1'b1;
                period_r     <= cnt_inc;
                cnt_r        <= '0;
                period_sat_r <= 1'b0;
            end else begin
                wrap_r <= 1'b0;
                cnt_r  <= cnt_inc;
                if (cnt_inc == ALL_ONES) begin
                    period_sat_r <= 1'b1;
                end
            end
        end else begin
            wrap_r <= 1'b0;
        end
    end

    assign bus.q          = q_r;
    assign bus.bit_out    = bits_r;
    assign bus.wrap       = wrap_r;
    assign bus.period     = period_r;
    assign bus.period_sat = period_sat_r;

endmodule

// File: tb/tb_lfsr_galois_gen.sv
// Bench for lfsr_galois_gen: three instances (W=4 STEPS=1, W=4 STEPS=2, W=26 default)
// checked against a polynomial-arithmetic reference model, a constant vector table
// and a few hand-written corner sequences.
module tb_lfsr_galois_gen;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    lfsr_galois_gen_if #(.WIDTH(4),  .STEPS(1)) if4  ();
    lfsr_galois_gen_if #(.WIDTH(4),  .STEPS(2)) if4s2();
    lfsr_galois_gen_if #(.WIDTH(26), .STEPS(1)) if26 ();

    lfsr_galois_gen #(.WIDTH(4), .TAPS(4'b0010), .SEED(4'd1), .STEPS(1)) dut4 (
        .clk(clk), .rst(rst), .bus(if4)
    );
    lfsr_galois_gen #(.WIDTH(4), .TAPS(4'b0010), .SEED(4'd1), .STEPS(2)) dut4s2 (
        .clk(clk), .rst(rst), .bus(if4s2)
    );
    lfsr_galois_gen dut26 (
        .clk(clk), .rst(rst), .bus(if26)
    );

    typedef struct {
        longint q;
        longint seed;
        longint cnt;
        longint period;
        longint bits;
        bit     wrap;
        bit     sat;
    } model_t;

    typedef struct {
        bit       en;
        logic [3:0] exp_q4;
        logic [3:0] exp_q4s2;
        bit       exp_wrap;
    } vec_t;

    model_t m4, m4s2, m26;
    int n_checks = 0;
    int n_pass   = 0;

    // Compare one observed value against the bench's expectation.
    task automatic check_val(input string name, input longint act, input longint exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference: state is a polynomial over GF(2); one shift multiplies by x mod P(x).
    task automatic model_cycle(inout model_t m, input int w, input longint taps,
                               input int steps, input longint seed_p,
                               input bit r, input bit ld, input bit e, input longint din);
        longint mask, s, nxt_cnt;
        mask = (64'd1 << w) - 1;
        if (r) begin
            m.seed = (seed_p == 0) ? 1 : seed_p;
            m.q = m.seed; m.bits = 0; m.wrap = 0; m.period = 0; m.sat = 0; m.cnt = 0;
        end else if (ld) begin
            m.seed = ((din & mask) != 0) ? (din & mask) : 1;
            m.q = m.seed; m.cnt = 0; m.wrap = 0; m.bits = 0;
        end else if (m.q == 0) begin
            m.q = 1; m.cnt = 0; m.wrap = 0;
        end else if (e) begin
            s = m.q;
            m.bits = 0;
            for (int j = 0; j < steps; j++) begin
                m.bits |= ((s >> (w - 1)) & 1) << j;
                s = s << 1;
                if (((s >> w) & 1) != 0) s ^= (64'd1 << w) | taps | 1;
            end
            m.q = s & mask;
            nxt_cnt = (m.cnt == mask) ? mask : m.cnt + 1;
            if (m.q == m.seed) begin
                m.wrap = 1; m.period = nxt_cnt; m.cnt = 0; m.sat = 0;
            end else begin
                m.wrap = 0; m.cnt = nxt_cnt;
                if (nxt_cnt == mask) m.sat = 1;
            end
        end else begin
            m.wrap = 0;
        end
    endtask

    // Compare all registered outputs of one instance with its model.
    task automatic checkOutput(input string name, input model_t m, input longint q,
                               input longint bits, input bit wrap, input longint period,
                               input bit sat);
        check_val({name, ".q"},          q,      m.q);
        check_val({name, ".bit_out"},    bits,   m.bits);
        check_val({name, ".wrap"},       wrap,   m.wrap);
        check_val({name, ".period"},     period, m.period);
        check_val({name, ".period_sat"}, sat,    m.sat);
    endtask

    // Advance one clock: models see the inputs present at the edge, outputs checked 1 after.
    task automatic tick();
        @(posedge clk);
        model_cycle(m4,   4,  64'h2,   1, 1, rst, if4.load,   if4.en,   longint'(if4.din));
        model_cycle(m4s2, 4,  64'h2,   2, 1, rst, if4s2.load, if4s2.en, longint'(if4s2.din));
        model_cycle(m26,  26, 64'h182, 1, 1, rst, if26.load,  if26.en,  longint'(if26.din));
        #1;
        checkOutput("w4",   m4,   longint'(if4.q),   longint'(if4.bit_out),   if4.wrap,
                    longint'(if4.period),   if4.period_sat);
        checkOutput("w4s2", m4s2, longint'(if4s2.q), longint'(if4s2.bit_out), if4s2.wrap,
                    longint'(if4s2.period), if4s2.period_sat);
        checkOutput("w26",  m26,  longint'(if26.q),  longint'(if26.bit_out),  if26.wrap,
                    longint'(if26.period),  if26.period_sat);
    endtask

    // Drive one cycle of inputs for all instances, then clock.
    task automatic applyStimulus(input bit r, input bit e4, input bit l4, input logic [3:0] d4,
                                 input bit e4b, input bit e26);
        rst        = r;
        if4.en     = e4;
        if4.load   = l4;
        if4.din    = d4;
        if4s2.en   = e4b;
        if4s2.load = 1'b0;
        if4s2.din  = '0;
        if26.en    = e26;
        if26.load  = 1'b0;
        if26.din   = '0;
        tick();
    endtask

    initial begin
        vec_t tbl[15];
        logic [3:0] seq1[16];
        seq1 = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'h6, 4'hC, 4'hB,
                 4'h5, 4'hA, 4'h7, 4'hE, 4'hF, 4'hD, 4'h9, 4'h1};
        for (int k = 0; k < 15; k++) begin
            tbl[k].en       = 1'b1;
            tbl[k].exp_q4   = seq1[k + 1];
            tbl[k].exp_q4s2 = seq1[(2 * (k + 1)) % 15];
            tbl[k].exp_wrap = (k == 14);
        end

        m4 = '{default: 0}; m4s2 = '{default: 0}; m26 = '{default: 0};

        // Reset state
        applyStimulus(1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
        check_val("reset.q4",      longint'(if4.q),      1);
        check_val("reset.period4", longint'(if4.period), 0);
        check_val("reset.q26",     longint'(if26.q),     1);

        // Full W=4 cycle from the vector table, STEPS=1 and STEPS=2 side by side
        for (int k = 0; k < 15; k++) begin
            applyStimulus(1'b0, tbl[k].en, 1'b0, 4'h0, tbl[k].en, 1'b1);
            check_val($sformatf("tbl%0d.q4", k),    longint'(if4.q),    longint'(tbl[k].exp_q4));
            check_val($sformatf("tbl%0d.q4s2", k),  longint'(if4s2.q),  longint'(tbl[k].exp_q4s2));
            check_val($sformatf("tbl%0d.wrap4", k), longint'(if4.wrap), longint'(tbl[k].exp_wrap));
            check_val($sformatf("tbl%0d.wrap4s2", k), longint'(if4s2.wrap), longint'(tbl[k].exp_wrap));
            if (k == 0) check_val("w26.first_step", longint'(if26.q), 64'h2);
        end
        check_val("tbl.period4",   longint'(if4.period),   15);
        check_val("tbl.period4s2", longint'(if4s2.period), 15);

        // Default config: after 26 enabled cycles the MSB folds into the taps
        for (int k = 0; k < 11; k++) applyStimulus(1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1);
        check_val("w26.after26", longint'(if26.q), 64'h183);

        // Loading zero substitutes 1; load with en loads without advancing
        applyStimulus(1'b0, 1'b0, 1'b1, 4'h0, 1'b0, 1'b0);
        check_val("load0.q4", longint'(if4.q), 1);
        applyStimulus(1'b0, 1'b1, 1'b1, 4'hA, 1'b0, 1'b0);
        check_val("load_en.q4", longint'(if4.q), 64'hA);
        for (int k = 1; k <= 15; k++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
            if (k == 14) check_val("load.nowrap14", longint'(if4.wrap), 0);
        end
        check_val("load.wrap",   longint'(if4.wrap),   1);
        check_val("load.q_seed", longint'(if4.q),      64'hA);
        check_val("load.period", longint'(if4.period), 15);

        // Random en gating against the model; every wrap must still report 15
        for (int k = 0; k < 1000; k++) begin
            applyStimulus(1'b0, 1'($urandom_range(0, 1)), 1'b0, 4'h0,
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            if (m4.wrap)   check_val("rand.period4",   longint'(if4.period),   15);
            if (m4s2.wrap) check_val("rand.period4s2", longint'(if4s2.period), 15);
        end

        // Reset mid-run dominates a simultaneous load
        for (int k = 0; k < 7; k++) applyStimulus(1'b0, 1'b1, 1'b0, 4'h0, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b1, 4'h5, 1'b1, 1'b1);
        check_val("rst_mid.q4",      longint'(if4.q),      1);
        check_val("rst_mid.period4", longint'(if4.period), 0);
        check_val("rst_mid.wrap4",   longint'(if4.wrap),   0);
        applyStimulus(1'b0, 1'b1, 1'b0, 4'h0, 1'b1, 1'b1);
        check_val("rst_mid.step_q4", longint'(if4.q), 64'h2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/lfsr_galois_gen.md
Name: lfsr_galois_gen

Overview:
- Parametrised Galois-form LFSR. Generalises the fixed 26-bit scrambler/PRBS generator in width, tap polynomial, reset seed and steps-per-clock.
- Adds an advance enable, zero-lockout protection and period (wrap) detection with a measured period length.
- Used as the PRBS/test-pattern source and scrambler keystream in the lab datapaths.

Parameters:
- WIDTH, 26, state width W (>=3).
- TAPS, 26'h0000182, feedback mask. Bit i=1 XORs the outgoing MSB into stage i. Bit 0 is ignored, because stage 0 always takes the MSB. The default gives x^26+x^8+x^7+x^1+1 feedback.
- SEED, 1, reset state. Must be nonzero; if SEED==0, the block uses 1.
- STEPS, 1, LFSR shifts per enabled clock (1..WIDTH), combinationally unrolled.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- en  in  1  advance state by STEPS shifts this cycle.
- load  in  1  load din as new seed (priority over en).
- din  in  WIDTH  seed value for load.
- q  out  WIDTH  current state s[W-1:0], registered.
- bit_out  out  STEPS  serial bits shifted out this cycle, registered. Bit j = MSB before shift j.
- wrap  out  1  one-cycle pulse: state returned to the active seed.
- period  out  WIDTH  enabled-cycle count of the last completed wrap, registered.
- period_sat  out  1  period counter saturated before a wrap occurred.

Behaviour:
- Single shift f(s): s'[0]=s[W-1]; s'[i]=s[i-1]^(TAPS[i]&s[W-1]) for i=1..W-1.
- Per enabled cycle, state <= f^STEPS(s). The update is pure combinational unroll, with no extra latency.
- Priority per cycle, checked in this order: rst, load, zero-lockout, en, hold.
- rst: q<=SEED (1 if SEED==0), active_seed<=same, bit_out<=0, wrap<=0, period<=0, period_sat<=0, cnt<=0.
- load: q<=(|din)?din:1 and active_seed<=same value. cnt<=0, wrap<=0, bit_out<=0; period and period_sat are held. load with en=1 loads only and does not advance.
- Zero-lockout: if q==0 with no rst/load, q<=1 and cnt<=0, with no wrap. This is unreachable in normal operation but must be implemented.
- en=1: q advances. bit_out captures the STEPS pre-shift MSBs. cnt<=cnt+1, saturating at all-ones; reaching saturation sets period_sat.
  - If the next state == active_seed: wrap=1 for exactly the cycle q shows the seed. period<=cnt+1 (saturated value if saturated), cnt<=0, period_sat<=0.
- en=0: everything holds, wrap<=0, bit_out holds.
- wrap/period latency: wrap asserts in the same cycle q first equals the seed after leaving it. period updates in that same cycle.
- Period for a primitive TAPS with STEPS=1 is 2^W-1. With STEPS=k it is (2^W-1)/gcd(k, 2^W-1) cycles.
- Width rules: cnt and period are WIDTH bits. The default W=26 period (67,108,863) fits in WIDTH bits and does not saturate. For non-primitive TAPS a shorter cycle may never include the seed; period_sat then reports this.
- No combinational input-to-output paths; all outputs are registered.

Test Plan:
- W=4, TAPS=4'b0010, SEED=1, STEPS=1, en held high after reset:
  - q sequence must be 0001→0010→0100→1000→0011→0110→1100→1011→0101→1010→0111→1110→1111→1101→1001→0001.
  - wrap pulses with the final 0001, period=15.
  - This repeats every 15 cycles.
- Same config, STEPS=2: q goes 0001→0100→0011→1100→0101. Wrap after 15 cycles with period=15, since gcd(2,15)=1. bit_out per cycle equals the two corresponding MSBs from the STEPS=1 run.
- Load: load=1, din=4'b0000 → q=0001. load with din=1010, en=1 in the same cycle → q=1010 with no advance. The next wrap occurs at q=1010 after 15 enabled cycles.
- Default W=26, SEED=1: after 1 enabled cycle q=26'h0000002. After 26 enabled cycles q has the taps applied, i.e. bit0=1 and bits 1,7,8 set (q=26'h0000183). The bench compares against a reference model for 1000 cycles.
- en gating: toggle en randomly. q, cnt, bit_out hold on en=0, and period still equals 15 enabled cycles (W=4 config).
- Reset mid-run: assert rst after 7 steps → next cycle q=SEED, period=0, wrap=0. Reset dominates a simultaneous load.
